// File: rtl/bin2bcd_pkg.sv
// Shared constants, state encoding and helpers for the sequential
// binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd4;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_adj3.sv
// Combinational double-dabble cell: a BCD digit above 4 gets 3 added.
module bcd_digit_adj3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = (din > ADJ_THRESH) ? din + ADJ_ADD : din;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle shift-and-add-3 binary-to-BCD converter, one input bit per
// clock, with start/done handshake, overflow flag and leading-zero mask.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]             blank,
    output logic                          neg,
    output logic                          ovf
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = clog2(BIN_W);
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    state_t             state;
    logic [BIN_W-1:0]   mag;
    logic [BCD_W-1:0]   work;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_s;
    logic               sign_s;

    logic               sign_in;
    logic [BIN_W-1:0]   mag_in;
    logic [DIGITS-1:0]  blank_nx;
    logic               all_zero;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj3 u_adj (
            .din  (work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Most negative input negates to itself, which reads correctly as unsigned.
    always_comb begin
        sign_in = SIGNED && bin[BIN_W-1];
        mag_in  = sign_in ? (~bin) + BIN_W'(1) : bin;
    end

    always_comb begin
        blank_nx = '0;
        all_zero = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            all_zero    = all_zero & (work[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_nx[i] = all_zero & ~ovf_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mag    <= '0;
            work   <= '0;
            cnt    <= '0;
            ovf_s  <= 1'b0;
            sign_s <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bcd    <= '0;
            blank  <= BLANK_RST;
            neg    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag    <= mag_in;
                        sign_s <= sign_in;
                        work   <= '0;
                        ovf_s  <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Adjust then shift {ovf_s, work, mag} left by one.
                    {work, mag} <= {adj[BCD_W-2:0], mag, 1'b0};
                    ovf_s       <= ovf_s | adj[BCD_W-1];
                    cnt         <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= work;
                    neg   <= sign_s;
                    ovf   <= ovf_s;
                    blank <= blank_nx;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed, table-driven bench for bin2bcd_seq over three parameter sets:
// default, 3-digit (overflow) and signed input.
module tb_bin2bcd_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [11:0] bin0 = '0, bin1 = '0, bin2 = '0;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [15:0] bcd0, bcd2;
    logic [11:0] bcd1;
    logic [3:0]  blank0, blank2;
    logic [2:0]  blank1;
    logic        neg0, neg1, neg2;
    logic        ovf0, ovf1, ovf2;

    bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bin(bin0), .busy(busy0),
        .done(done0), .bcd(bcd0), .blank(blank0), .neg(neg0), .ovf(ovf0)
    );

    bin2bcd_seq #(.BIN_W(12), .DIGITS(3), .SIGNED(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bin(bin1), .busy(busy1),
        .done(done1), .bcd(bcd1), .blank(blank1), .neg(neg1), .ovf(ovf1)
    );

    bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2), .busy(busy2),
        .done(done2), .bcd(bcd2), .blank(blank2), .neg(neg2), .ovf(ovf2)
    );

    typedef struct {
        int unsigned inst;
        logic [11:0] bin;
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic        neg;
        logic        ovf;
    } vec_t;

    vec_t vecs[15];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_in(input int unsigned k, input logic s, input logic [11:0] b);
        case (k)
            0: begin start0 = s; bin0 = b; end
            1: begin start1 = s; bin1 = b; end
            2: begin start2 = s; bin2 = b; end
            default: ;
        endcase
    endtask

    task automatic get_out(input int unsigned k, output logic bs, output logic dn,
                           output logic [15:0] bc, output logic [3:0] bl,
                           output logic ng, output logic ov);
        bs = 1'b0; dn = 1'b0; bc = '0; bl = '0; ng = 1'b0; ov = 1'b0;
        case (k)
            0: begin bs = busy0; dn = done0; bc = bcd0; bl = blank0; ng = neg0; ov = ovf0; end
            1: begin bs = busy1; dn = done1; bc = {4'h0, bcd1}; bl = {1'b0, blank1}; ng = neg1; ov = ovf1; end
            2: begin bs = busy2; dn = done2; bc = bcd2; bl = blank2; ng = neg2; ov = ovf2; end
            default: ;
        endcase
    endtask

    // Pulse start for one edge, then wait (bounded) for done and return the result.
    task automatic convert(input int unsigned k, input logic [11:0] b, input string nm,
                           output logic [15:0] rbc, output logic [3:0] rbl,
                           output logic rng, output logic rov);
        logic bs, dn, ng, ov;
        logic [15:0] bc;
        logic [3:0]  bl;
        logic found;
        int lat;
        found = 1'b0;
        lat = 0;
        rbc = '0; rbl = '0; rng = 1'b0; rov = 1'b0;
        @(negedge clk);
        set_in(k, 1'b1, b);
        @(posedge clk);
        #1 set_in(k, 1'b0, b);
        for (int e = 1; e <= 40 && !found; e++) begin
            @(posedge clk);
            #1;
            get_out(k, bs, dn, bc, bl, ng, ov);
            if (e == 1) chk({nm, " busy"}, {31'b0, bs}, 32'd1);
            if (dn) begin
                found = 1'b1;
                lat = e;
                rbc = bc; rbl = bl; rng = ng; rov = ov;
            end
        end
        chk({nm, " latency"}, lat, 32'd13);
        @(posedge clk);
        #1;
        get_out(k, bs, dn, bc, bl, ng, ov);
        chk({nm, " done_pulse"}, {31'b0, dn}, 32'd0);
    endtask

    initial begin
        logic bs, dn, ng, ov;
        logic [15:0] bc, bc1, bc2;
        logic [3:0]  bl, bl2;
        int first, second, ndone;

        vecs[0]  = '{0, 12'd4095, 16'h4095, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{0, 12'd0,    16'h0000, 4'b1110, 1'b0, 1'b0};
        vecs[2]  = '{0, 12'd7,    16'h0007, 4'b1110, 1'b0, 1'b0};
        vecs[3]  = '{0, 12'd305,  16'h0305, 4'b1000, 1'b0, 1'b0};
        vecs[4]  = '{0, 12'd1000, 16'h1000, 4'b0000, 1'b0, 1'b0};
        vecs[5]  = '{0, 12'd10,   16'h0010, 4'b1100, 1'b0, 1'b0};
        vecs[6]  = '{1, 12'd1000, 16'h0000, 4'b0000, 1'b0, 1'b1};
        vecs[7]  = '{1, 12'd999,  16'h0999, 4'b0000, 1'b0, 1'b0};
        vecs[8]  = '{1, 12'd4095, 16'h0095, 4'b0000, 1'b0, 1'b1};
        vecs[9]  = '{1, 12'd42,   16'h0042, 4'b0100, 1'b0, 1'b0};
        vecs[10] = '{2, 12'h800,  16'h2048, 4'b0000, 1'b1, 1'b0};
        vecs[11] = '{2, 12'hFFF,  16'h0001, 4'b1110, 1'b1, 1'b0};
        vecs[12] = '{2, 12'h7FF,  16'h2047, 4'b0000, 1'b0, 1'b0};
        vecs[13] = '{2, 12'hF85,  16'h0123, 4'b1000, 1'b1, 1'b0};
        vecs[14] = '{2, 12'h000,  16'h0000, 4'b1110, 1'b0, 1'b0};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        get_out(0, bs, dn, bc, bl, ng, ov);
        chk("rst busy",  {31'b0, bs}, 32'd0);
        chk("rst done",  {31'b0, dn}, 32'd0);
        chk("rst bcd",   {16'b0, bc}, 32'h0);
        chk("rst blank", {28'b0, bl}, 32'b1110);
        chk("rst neg",   {31'b0, ng}, 32'd0);
        chk("rst ovf",   {31'b0, ov}, 32'd0);
        chk("rst blank3", {29'b0, blank1}, 32'b110);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            convert(vecs[i].inst, vecs[i].bin, nm, bc, bl, ng, ov);
            chk({nm, " bcd"},   {16'b0, bc}, {16'b0, vecs[i].bcd});
            chk({nm, " blank"}, {28'b0, bl}, {28'b0, vecs[i].blank});
            chk({nm, " neg"},   {31'b0, ng}, {31'b0, vecs[i].neg});
            chk({nm, " ovf"},   {31'b0, ov}, {31'b0, vecs[i].ovf});
        end

        // Starts during SHIFT and DONE are ignored; start right after done is taken.
        first = 0; second = 0; ndone = 0;
        bc1 = '0; bc2 = '0; bl2 = '0;
        @(negedge clk);
        set_in(0, 1'b1, 12'd1234);
        @(posedge clk);
        #1 set_in(0, 1'b0, 12'd1234);
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            get_out(0, bs, dn, bc, bl, ng, ov);
            if (dn) begin
                ndone++;
                if (first == 0) begin
                    first = e; bc1 = bc;
                end else if (second == 0) begin
                    second = e; bc2 = bc; bl2 = bl;
                end
            end
            case (e)
                2, 12, 13: set_in(0, 1'b1, 12'd9);
                3, 14:     set_in(0, 1'b0, 12'd9);
                default: ;
            endcase
        end
        chk("b2b first_lat",  first, 32'd13);
        chk("b2b first_bcd",  {16'b0, bc1}, 32'h1234);
        chk("b2b second_lat", second, 32'd27);
        chk("b2b second_bcd", {16'b0, bc2}, 32'h0009);
        chk("b2b second_blank", {28'b0, bl2}, 32'b1110);
        chk("b2b done_count", ndone, 32'd2);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        set_in(0, 1'b1, 12'd4095);
        @(posedge clk);
        #1 set_in(0, 1'b0, 12'd4095);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 get_out(0, bs, dn, bc, bl, ng, ov);
        chk("abort busy",  {31'b0, bs}, 32'd0);
        chk("abort done",  {31'b0, dn}, 32'd0);
        chk("abort bcd",   {16'b0, bc}, 32'h0);
        chk("abort blank", {28'b0, bl}, 32'b1110);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            get_out(0, bs, dn, bc, bl, ng, ov);
            if (dn) ndone++;
        end
        chk("abort no_done", ndone, 32'd0);
        convert(0, 12'd321, "post_rst", bc, bl, ng, ov);
        chk("post_rst bcd",   {16'b0, bc}, 32'h0321);
        chk("post_rst blank", {28'b0, bl}, 32'b1000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Generalises the combinational 12-bit/4-digit converter:
  - configurable input width and digit count
  - optional signed input
  - start/done handshake
  - overflow detection
  - leading-zero blanking mask
- Sits between motor speed/position counters and the 7-segment display drivers; replaces a wide combinational chain with a small registered datapath.

Parameters:
- BIN_W, 12: binary input width in bits (2..32).
- DIGITS, 4: number of BCD output digits (1..10).
- SIGNED, 0: 1 means bin is two's complement; magnitude is converted and the sign is reported on neg.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request conversion; bin is sampled in the same cycle; ignored unless idle.
- bin  in  BIN_W  binary value to convert.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse: result outputs updated this cycle.
- bcd  out  4*DIGITS  packed digits; digit 0 (ones) in [3:0], digit i in [4i+3:4i].
- blank  out  DIGITS  bit i = 1 when digit i is a leading zero (bit 0 always 0).
- neg  out  1  input was negative (always 0 when SIGNED=0).
- ovf  out  1  magnitude ≥ 10^DIGITS; bcd holds the low DIGITS digits only.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE.
  - busy=0, done=0, neg=0, ovf=0, bcd=0, blank = all ones except bit 0.
  - Internal shift/BCD/counter registers cleared.
  - Reset mid-conversion aborts it; no done is issued.
- IDLE: on start=1 latch the magnitude and clear the working BCD register and bit counter, then go to SHIFT.
  - Magnitude is bin when SIGNED=0 or bin MSB=0, otherwise the two's-complement negation.
  - Latch the sign flag.
  - Magnitude is held in BIN_W bits; the most negative input (e.g. -2048 at BIN_W=12) yields 2048 unsigned, with no loss.
  - busy=1 from the next cycle.
- SHIFT: exactly BIN_W cycles. Each cycle:
  1. Every digit >4 gets +3 (4-bit result).
  2. The whole {ovf_sticky, BCD, magnitude} register shifts left by one.
  - A 1 shifted out of the top digit sets ovf_sticky.
  - Counter runs 0..BIN_W-1; on the last count go to DONE.
- DONE: one cycle, then IDLE.
  - Register outputs: bcd, neg, ovf (= ovf_sticky), blank.
  - done=1 this cycle only; busy=1 this cycle, 0 afterwards.
- Latency: start sampled at edge N; done observed high for the cycle following edge N+BIN_W+1.
  - Back-to-back: a new start is accepted on the cycle after done, giving a throughput of 1 conversion per BIN_W+2 cycles.
- start while busy=1 (including the DONE cycle) is ignored; no queuing.
- Outputs bcd/blank/neg/ovf hold their value between done pulses; they are never partially updated.
- blank: computed from the final digits.
  - bit i (i≥1) = 1 iff digits i..DIGITS-1 are all zero.
  - Zero input gives blank = all ones except bit 0.
  - blank is forced to all zeros when ovf=1.
- neg for a zero result is 0 (no negative zero).

Decomposition:
- Shared package bin2bcd_pkg:
  - BCD_DIGIT_W=4
  - ADJ_THRESH=4 and ADJ_ADD=3
  - state enum {IDLE, SHIFT, DONE}
  - counter width function clog2(BIN_W)
- One sub-module: bcd_digit_adj3, combinational 4-bit "if >4 add 3" cell, instantiated DIGITS times via generate.

Test Plan:
- Default params, bin=4095, start pulse → done exactly 13 cycles after start edge; bcd=0x4095, blank=0000, ovf=0, neg=0.
- bin=0 → bcd=0x0000, blank=1110; bin=7 → bcd=0x0007, blank=1110; bin=305 → blank=1000.
- DIGITS=3, bin=1000 → ovf=1, bcd=0x000, blank=000; bin=999 → ovf=0, bcd=0x999.
- SIGNED=1, BIN_W=12: bin=0x800 (-2048) → neg=1, bcd=0x2048; bin=0xFFF (-1) → neg=1, bcd=0x0001, blank=1110.
- Start bin=1234, reassert start with bin=9 at cycles 3 and 13 (DONE) → single done, bcd=0x1234; start the cycle after done → second result 0x0009 after 13 more cycles.
- Assert rst_n=0 at cycle 5 of a conversion → busy/done drop immediately, bcd returns to 0, no done; a fresh start after release converts correctly.
